// File: rtl/des_out_serializer.sv
`default_nettype none
// ============================================================================
// Module   : des_out_serializer
// Brief    : Buffers 64-bit DES result blocks in a small FIFO and emits them
//            MSB-first as a valid/ready byte stream. Optional drop counter
//            enabled by defining DES_SER_DROP_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module des_out_serializer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [63:0]              blk_in,
   input  logic                     blk_valid,
   output logic                     blk_ready,
   output logic [7:0]               byte_out,
   output logic                     byte_valid,
   input  logic                     byte_ready,
   output logic                     byte_last,
   output logic [$clog2(DEPTH):0]   fill
`ifdef DES_SER_DROP_CNT_EN
   ,
   output logic [CNT_W-1:0]         drop_cnt
`endif
);

   localparam int             AW     = $clog2(DEPTH);
   localparam logic [AW:0]    C_FULL = (AW+1)'(DEPTH);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [63:0]        r_mem [DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [AW:0]        r_fill;
   logic [63:0]        r_shreg;
   logic [2:0]         r_idx;
   logic               w_push;
   logic               w_pop;
   logic               w_shift;

   // Full means full: a pop in the same cycle does not open a slot for the writer.
   assign blk_ready = (r_fill != C_FULL);
   assign w_push    = blk_valid && blk_ready;
   assign fill      = r_fill;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_shift     = 1'b0;
      byte_valid  = 1'b0;
      byte_out    = 8'h00;
      byte_last   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_fill != '0) begin
               w_pop       = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            byte_valid = 1'b1;
            byte_out   = r_shreg[63:56];
            byte_last  = (r_idx == 3'd7);
            if (byte_ready) begin
               if (r_idx != 3'd7)      w_shift     = 1'b1;
               else if (r_fill != '0)  w_pop       = 1'b1;
               else                    w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Storage carries no reset; only pointers and occupancy define validity.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= blk_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_fill <= r_fill + 1'b1;
            2'b01:   r_fill <= r_fill - 1'b1;
            default: r_fill <= r_fill;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_shreg <= '0;
         r_idx   <= '0;
      end else if (w_pop) begin
         r_shreg <= r_mem[r_rd_ptr];
         r_idx   <= '0;
      end else if (w_shift) begin
         r_shreg <= {r_shreg[55:0], 8'h00};
         r_idx   <= r_idx + 1'b1;
      end
   end

`ifdef DES_SER_DROP_CNT_EN
   logic [CNT_W-1:0] r_drop_cnt;

   always_ff @(posedge clk) begin
      if (reset)
         r_drop_cnt <= '0;
      else if (blk_valid && !blk_ready && (r_drop_cnt != '1))
         r_drop_cnt <= r_drop_cnt + 1'b1;
   end

   assign drop_cnt = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_des_out_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_out_serializer
// Brief    : Self-checking bench for des_out_serializer: directed scenarios
//            plus random traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_out_serializer;

   localparam int DEPTH = 4;
   localparam int CNT_W = 8;
   localparam int FW    = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            reset;
   logic [63:0]     blk_in;
   logic            blk_valid;
   logic            blk_ready;
   logic [7:0]      byte_out;
   logic            byte_valid;
   logic            byte_ready;
   logic            byte_last;
   logic [FW-1:0]   fill;
`ifdef DES_SER_DROP_CNT_EN
   logic [CNT_W-1:0] drop_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: queue of stored blocks, queue of bytes still to emit
   logic [63:0] m_fifo[$];
   logic [7:0]  m_bytes[$];
   int          m_drops;

   // observed handshaken bytes and their byte_last flags
   logic [7:0]  got_q[$];
   int          got_last;

   des_out_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .blk_in     (blk_in),
      .blk_valid  (blk_valid),
      .blk_ready  (blk_ready),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .byte_last  (byte_last),
      .fill       (fill)
`ifdef DES_SER_DROP_CNT_EN
      ,
      .drop_cnt   (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input logic rst, input logic bv, input logic [63:0] bi, input logic br);
      logic accept;
      logic [63:0] blk;
      if (rst) begin
         m_fifo.delete();
         m_bytes.delete();
         m_drops = 0;
         return;
      end
      accept = bv && (m_fifo.size() < DEPTH);
      if (bv && !accept && m_drops < (1 << CNT_W) - 1) m_drops++;
      if (m_bytes.size() != 0 && br) void'(m_bytes.pop_front());
      if (m_bytes.size() == 0 && m_fifo.size() != 0) begin
         blk = m_fifo.pop_front();
         for (int i = 0; i < 8; i++) m_bytes.push_back(blk[63-8*i -: 8]);
      end
      if (accept) m_fifo.push_back(bi);
   endtask

   task automatic compare_outputs();
      logic act;
      act = (m_bytes.size() != 0);
      check("byte_valid", {63'd0, byte_valid}, {63'd0, act});
      check("byte_out",   {56'd0, byte_out},   act ? {56'd0, m_bytes[0]} : 64'd0);
      check("byte_last",  {63'd0, byte_last},  {63'd0, act && m_bytes.size() == 1});
      check("fill",       64'(fill),           64'(m_fifo.size()));
      check("blk_ready",  {63'd0, blk_ready},  {63'd0, m_fifo.size() != DEPTH});
`ifdef DES_SER_DROP_CNT_EN
      check("drop_cnt",   64'(drop_cnt),       64'(m_drops));
`endif
   endtask

   // Entered and left at a falling edge: drive, clock, step model, compare.
   task automatic cycle(input logic rst, input logic bv, input logic [63:0] bi, input logic br);
      reset      = rst;
      blk_valid  = bv;
      blk_in     = bi;
      byte_ready = br;
      if (byte_valid && br && !rst) begin
         got_q.push_back(byte_out);
         if (byte_last) got_last++;
      end
      @(posedge clk);
      model_step(rst, bv, bi, br);
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, 64'd0, 1'b0);
      cycle(1'b1, 1'b0, 64'd0, 1'b0);
      got_q.delete();
      got_last = 0;
   endtask

   initial begin
      logic [63:0] exp_blk;
      logic [63:0] blks [6];
      logic [7:0]  exp_b;

      reset = 1'b1; blk_valid = 1'b0; blk_in = '0; byte_ready = 1'b0;
      got_last = 0; m_drops = 0;
      @(negedge clk);

      // reset state
      do_reset();
      check("rst_byte_valid", {63'd0, byte_valid}, 64'd0);
      check("rst_blk_ready",  {63'd0, blk_ready},  64'd1);
      check("rst_fill",       64'(fill),           64'd0);

      // single block with 1-cycle latency into the shifter
      exp_blk = 64'h85E813540F0AB405;
      cycle(1'b0, 1'b1, exp_blk, 1'b1);
      check("lat_fill", 64'(fill), 64'd1);
      check("lat_valid_early", {63'd0, byte_valid}, 64'd0);
      cycle(1'b0, 1'b0, 64'd0, 1'b1);
      check("lat_valid", {63'd0, byte_valid}, 64'd1);
      check("lat_first", {56'd0, byte_out}, 64'h85);
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 64'd0, 1'b1);
      check("single_cnt", 64'(got_q.size()), 64'd8);
      for (int i = 0; i < 8 && i < got_q.size(); i++)
         check("single_byte", {56'd0, got_q[i]}, {56'd0, exp_blk[63-8*i -: 8]});
      check("single_last", 64'(got_last), 64'd1);

      // back-to-back blocks
      do_reset();
      cycle(1'b0, 1'b1, 64'h0123456789ABCDEF, 1'b1);
      cycle(1'b0, 1'b1, 64'hFEDCBA9876543210, 1'b1);
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 64'd0, 1'b1);
      check("b2b_cnt",  64'(got_q.size()), 64'd16);
      check("b2b_last", 64'(got_last),     64'd2);

      // backpressure on the third byte
      do_reset();
      cycle(1'b0, 1'b1, exp_blk, 1'b1);
      for (int i = 0; i < 20 && got_q.size() < 2; i++) cycle(1'b0, 1'b0, 64'd0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b0, 64'd0, 1'b0);
         check("stall_byte",  {56'd0, byte_out},   64'h13);
         check("stall_valid", {63'd0, byte_valid}, 64'd1);
      end
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 64'd0, 1'b1);
      check("bp_cnt", 64'(got_q.size()), 64'd8);
      for (int i = 0; i < 8 && i < got_q.size(); i++)
         check("bp_byte", {56'd0, got_q[i]}, {56'd0, exp_blk[63-8*i -: 8]});

      // fill and overflow
      do_reset();
      blks[0] = 64'hAAAAAAAAAAAAAAAA; blks[1] = 64'hBBBBBBBBBBBBBBBB;
      blks[2] = 64'hCCCCCCCCCCCCCCCC; blks[3] = 64'hDDDDDDDDDDDDDDDD;
      blks[4] = 64'hEEEEEEEEEEEEEEEE; blks[5] = 64'hFFFFFFFFFFFFFFFF;
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, blks[i], 1'b0);
      check("ovf_fill",  64'(fill),          64'(DEPTH));
      check("ovf_ready", {63'd0, blk_ready}, 64'd0);
`ifdef DES_SER_DROP_CNT_EN
      check("ovf_drop", 64'(drop_cnt), 64'd1);
`endif
      for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0, 64'd0, 1'b1);
      check("drain_cnt", 64'(got_q.size()), 64'd40);
      for (int i = 0; i < 40 && i < got_q.size(); i++) begin
         exp_b = blks[i/8][7:0];
         check("drain_byte", {56'd0, got_q[i]}, {56'd0, exp_b});
      end

      // simultaneous last-byte pop and rejected write while full
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, blks[i], 1'b0);
      check("sim_full", 64'(fill), 64'(DEPTH));
      for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 64'd0, 1'b1);
      check("sim_last", {63'd0, byte_last}, 64'd1);
      cycle(1'b0, 1'b1, 64'h1234123412341234, 1'b1);
      check("sim_fill",  64'(fill),          64'(DEPTH-1));
      check("sim_ready", {63'd0, blk_ready}, 64'd1);
      for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, 64'd0, 1'b1);
      check("sim_cnt", 64'(got_q.size()), 64'd40);

      // reset in the middle of a block
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, blks[i], 1'b1);
      for (int i = 0; i < 20 && got_q.size() < 4; i++) cycle(1'b0, 1'b0, 64'd0, 1'b1);
      check("mid_fill_pre", 64'(fill), 64'd2);
      cycle(1'b1, 1'b0, 64'd0, 1'b1);
      check("mid_valid", {63'd0, byte_valid}, 64'd0);
      check("mid_fill",  64'(fill),           64'd0);
      check("mid_ready", {63'd0, blk_ready},  64'd1);
      got_q.delete();
      cycle(1'b0, 1'b1, 64'h0000000000000001, 1'b1);
      for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 64'd0, 1'b1);
      check("mid_cnt", 64'(got_q.size()), 64'd8);
      for (int i = 0; i < 8 && i < got_q.size(); i++)
         check("mid_byte", {56'd0, got_q[i]}, (i == 7) ? 64'h01 : 64'h00);

      // random traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 199) == 0),
               ($urandom_range(0, 1) == 1),
               {$urandom, $urandom},
               ($urandom_range(0, 9) < 7));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
